jt10_adpcma_rom_bridge: RTL and testbench
=========================================

// Module: jt10_adpcma_rom_bridge
// PURPOSE
//  Bridges the YM2610 ADPCM-A ROM port (adpcma_addr/bank/roe_n, adpcma_data) to a
//  16-bit word-wide SDRAM request/ack port. Sits directly below the YM2610 wrapper
//  and feeds adpcma_data. Holds the last fetched word as a one-entry cache, so
//  repeated byte reads within the same word do not generate SDRAM traffic.
// PARAMETERS
//  ROM_BASE  24'h000000  byte offset added to {bank,addr} before the word address is formed
// PORTS
//  clk           in   1   system clock; the only clock
//  rst_n         in   1   asynchronous reset, active low
//  adpcma_addr   in   20  byte address from the chip
//  adpcma_bank   in   4   bank select from the chip
//  adpcma_roe_n  in   1   ROM output enable from the chip, active low
//  adpcma_data   out  8   byte returned to the chip
//  rom_req       out  1   SDRAM request; level signal, held until ack
//  rom_addr      out  23  SDRAM word address
//  rom_ack       in   1   one-cycle pulse: rom_dout is valid
//  rom_dout      in   16  SDRAM word; low byte = even address
//  busy          out  1   high while in REQ state or while a pending slot is full
// BEHAVIOUR
//  - Byte address: ba = {bank,addr} + ROM_BASE, computed mod 2^24.
//    Word address: wa = ba[23:1]. Byte lane: ba[0] ? word[15:8] : word[7:0].
//  - Trigger, evaluated every clk: roe_n==0 AND (roe_n was 1 on the previous clk
//    OR ba differs from the last triggered ba).
//  - Hit: cache valid and wa==cache_wa. adpcma_data is updated 1 clk after the
//    trigger. No request is issued.
//  - Miss, state machine IDLE/REQ:
//    - IDLE: a miss sets rom_req=1 and rom_addr=wa on the next clk, then moves to REQ.
//    - REQ: rom_req holds until the clk on which rom_ack==1. On that clk:
//      cache <= rom_dout, cache_wa and valid are updated, rom_req <= 0,
//      adpcma_data <= selected byte (visible 1 clk after ack).
//  - Miss latency is 1 clk to rom_req plus the SDRAM latency plus 1 clk.
//  - Trigger while in REQ goes into one pending slot (ba); the latest trigger
//    overwrites it. After an ack, the pending entry is resolved in IDLE on the
//    next clk: a hit updates adpcma_data, a miss issues a new request.
//    Otherwise FSM returns to IDLE.
//  - Pending ba equal to the word just filled resolves as a hit; no request.
//  - rom_ack seen in IDLE is ignored. rom_addr holds its last value when idle.
//  - Reset (async, any state, including mid-request): adpcma_data=8'h00,
//    rom_req=0, rom_addr=0, busy=0, cache valid=0, pending cleared, FSM=IDLE.
//    The first access after reset is always a miss.
// CONFIGURATION
//  JT10_ADPCMA_PREFETCH_EN defined:
//    - Adds a second word buffer B. After any demand fill of word W, with no
//      pending demand, the bridge issues a request for W+1 (wraps mod 2^23)
//      into B.
//    - Hit check covers both buffers.
//    - A demand trigger arriving during a prefetch waits in the pending slot;
//      the prefetch is never aborted.
//    - When a prefetch completes and B becomes the demand word, B is promoted
//      to the primary buffer and the next prefetch is issued.
//  Not defined: single buffer only; rom_req is asserted for demand misses only.
// TESTING
//  1 Reset, roe_n=0, bank=0, addr=0x00010, mem[0x8]=16'hA55A, ack after 3 clk
//    -> rom_req=1 at T+1, rom_addr=0x000008, adpcma_data=8'h5A one clk after ack.
//  2 Then addr=0x00011 -> hit, no rom_req, adpcma_data=8'hA5 1 clk after change.
//  3 ROM_BASE=24'h100000, bank=4'hF, addr=0xFFFFF -> ba wraps to 24'h0FFFFF,
//    rom_addr=23'h07FFFF, high byte returned.
//  4 During REQ, trigger 0x20, then 0x40, before ack -> exactly two requests
//    (original, then 0x000020); 0x20 is never requested; data reflects 0x40.
//  5 Assert rst_n=0 while rom_req=1 -> rom_req=0 and adpcma_data=0 immediately;
//    a late ack after release is ignored; next read misses.
//  6 With PREFETCH_EN: read 0x100 -> requests 0x80 then 0x81; read 0x102
//    afterwards -> no new demand request, data from buffer B, prefetch of 0x82.

Source files
------------

// File: rtl/jt10_adpcma_rom_bridge.sv
// jt10_adpcma_rom_bridge
//   Bridges the YM2610 ADPCM-A byte-wide ROM port to a 16-bit word-wide
//   SDRAM request/ack port. The last fetched word is kept as a one-entry
//   cache, so byte reads that stay inside that word cause no SDRAM traffic.
//
//   Handshake: rom_req is a level that rises together with a stable
//   rom_addr and stays high, with rom_addr unchanged, until the clk on which
//   rom_ack is sampled high. rom_ack is a one-cycle pulse that qualifies
//   rom_dout. An ack seen while no request is outstanding is ignored.
//
//   Optional feature: define JT10_ADPCMA_PREFETCH_EN to add a second word
//   buffer (B). It is filled by a speculative request for the word that
//   follows every demand fill.
module jt10_adpcma_rom_bridge #(
  parameter logic [23:0] ROM_BASE = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] adpcma_addr,
  input  logic [3:0]  adpcma_bank,
  input  logic        adpcma_roe_n,
  output logic [7:0]  adpcma_data,
  output logic        rom_req,
  output logic [22:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_dout,
  output logic        busy
);

  // ST_REQ: demand fetch in flight. ST_PREF: prefetch into B in flight.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_PREF = 2'd2
  } state_t;

  state_t      state, state_nx;

  logic [23:0] ba;
  logic        roe_q;
  logic [23:0] last_ba;
  logic        trig;

  logic        req_nx;
  logic [22:0] addr_nx;
  logic [7:0]  data_nx;
  logic [15:0] a_word, a_word_nx;
  logic [22:0] a_wa, a_wa_nx;
  logic        a_valid, a_valid_nx;
  logic        pend_valid, pend_valid_nx;
  logic [23:0] pend_ba, pend_ba_nx;
  logic        req_odd, req_odd_nx;

  logic        act;
  logic [23:0] sel_ba;
  logic [22:0] sel_wa;
  logic        hit_a;

`ifdef JT10_ADPCMA_PREFETCH_EN
  logic [15:0] b_word, b_word_nx;
  logic [22:0] b_wa, b_wa_nx;
  logic        b_valid, b_valid_nx;
  logic        pf_want, pf_want_nx;
  logic [22:0] pf_wa, pf_wa_nx;
  logic        hit_b;
`endif

  function automatic logic [7:0] lane_sel(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : w[7:0];
  endfunction

  assign ba   = {adpcma_bank, adpcma_addr} + ROM_BASE;
  assign trig = !adpcma_roe_n && (roe_q || (ba != last_ba));

  // A trigger from the chip takes priority over an older pending entry.
  assign act    = trig || pend_valid;
  assign sel_ba = trig ? ba : pend_ba;
  assign sel_wa = sel_ba[23:1];
  assign hit_a  = a_valid && (a_wa == sel_wa);
`ifdef JT10_ADPCMA_PREFETCH_EN
  assign hit_b  = b_valid && (b_wa == sel_wa);
`endif

  assign busy = (state != ST_IDLE) || pend_valid;

  // Edge/change detector for the chip's read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roe_q   <= 1'b1;
      last_ba <= 24'h000000;
    end else begin
      roe_q <= adpcma_roe_n;
      if (trig) last_ba <= ba;
    end
  end

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    state_nx      = state;
    req_nx        = rom_req;
    addr_nx       = rom_addr;
    data_nx       = adpcma_data;
    a_word_nx     = a_word;
    a_wa_nx       = a_wa;
    a_valid_nx    = a_valid;
    pend_valid_nx = pend_valid;
    pend_ba_nx    = pend_ba;
    req_odd_nx    = req_odd;
`ifdef JT10_ADPCMA_PREFETCH_EN
    b_word_nx     = b_word;
    b_wa_nx       = b_wa;
    b_valid_nx    = b_valid;
    pf_want_nx    = pf_want;
    pf_wa_nx      = pf_wa;
`endif
    case (state)
      ST_IDLE: begin
        if (act) begin
          pend_valid_nx = 1'b0;
          if (hit_a) begin
            data_nx = lane_sel(a_word, sel_ba[0]);
`ifdef JT10_ADPCMA_PREFETCH_EN
          end else if (hit_b) begin
            // B becomes the demand word: promote it and look one word ahead.
            data_nx    = lane_sel(b_word, sel_ba[0]);
            a_word_nx  = b_word;
            a_wa_nx    = b_wa;
            a_valid_nx = 1'b1;
            b_valid_nx = 1'b0;
            pf_want_nx = 1'b1;
            pf_wa_nx   = b_wa + 23'd1;
`endif
          end else begin
            req_nx     = 1'b1;
            addr_nx    = sel_wa;
            req_odd_nx = sel_ba[0];
            state_nx   = ST_REQ;
`ifdef JT10_ADPCMA_PREFETCH_EN
            pf_want_nx = 1'b0;
`endif
          end
`ifdef JT10_ADPCMA_PREFETCH_EN
        end else if (pf_want) begin
          pf_want_nx = 1'b0;
          if (!(b_valid && (b_wa == pf_wa))) begin
            req_nx   = 1'b1;
            addr_nx  = pf_wa;
            state_nx = ST_PREF;
          end
`endif
        end
      end
      ST_REQ: begin
        if (trig) begin
          pend_valid_nx = 1'b1;
          pend_ba_nx    = ba;
        end
        if (rom_ack) begin
          a_word_nx  = rom_dout;
          a_wa_nx    = rom_addr;
          a_valid_nx = 1'b1;
          req_nx     = 1'b0;
          data_nx    = lane_sel(rom_dout, req_odd);
          state_nx   = ST_IDLE;
`ifdef JT10_ADPCMA_PREFETCH_EN
          if (!pend_valid && !trig) begin
            pf_want_nx = 1'b1;
            pf_wa_nx   = rom_addr + 23'd1;
          end
`endif
        end
      end
`ifdef JT10_ADPCMA_PREFETCH_EN
      ST_PREF: begin
        // Prefetches always complete; demand triggers wait in the pending slot.
        if (trig) begin
          pend_valid_nx = 1'b1;
          pend_ba_nx    = ba;
        end
        if (rom_ack) begin
          b_word_nx  = rom_dout;
          b_wa_nx    = rom_addr;
          b_valid_nx = 1'b1;
          req_nx     = 1'b0;
          state_nx   = ST_IDLE;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      rom_req     <= 1'b0;
      rom_addr    <= 23'h000000;
      adpcma_data <= 8'h00;
      a_word      <= 16'h0000;
      a_wa        <= 23'h000000;
      a_valid     <= 1'b0;
      pend_valid  <= 1'b0;
      pend_ba     <= 24'h000000;
      req_odd     <= 1'b0;
`ifdef JT10_ADPCMA_PREFETCH_EN
      b_word      <= 16'h0000;
      b_wa        <= 23'h000000;
      b_valid     <= 1'b0;
      pf_want     <= 1'b0;
      pf_wa       <= 23'h000000;
`endif
    end else begin
      state       <= state_nx;
      rom_req     <= req_nx;
      rom_addr    <= addr_nx;
      adpcma_data <= data_nx;
      a_word      <= a_word_nx;
      a_wa        <= a_wa_nx;
      a_valid     <= a_valid_nx;
      pend_valid  <= pend_valid_nx;
      pend_ba     <= pend_ba_nx;
      req_odd     <= req_odd_nx;
`ifdef JT10_ADPCMA_PREFETCH_EN
      b_word      <= b_word_nx;
      b_wa        <= b_wa_nx;
      b_valid     <= b_valid_nx;
      pf_want     <= pf_want_nx;
      pf_wa       <= pf_wa_nx;
`endif
    end
  end

endmodule

// File: tb/tb_jt10_adpcma_rom_bridge.sv
// Testbench for jt10_adpcma_rom_bridge. Two instances share the chip-side
// stimulus: dut uses ROM_BASE=0, dut_w uses ROM_BASE=24'h100000 for the
// address wrap case. Each has its own SDRAM responder model.
module tb_jt10_adpcma_rom_bridge;

  localparam logic [23:0] BASE_W = 24'h100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [19:0] adpcma_addr;
  logic [3:0]  adpcma_bank;
  logic        adpcma_roe_n;

  logic [7:0]  adpcma_data;
  logic        rom_req;
  logic [22:0] rom_addr;
  logic        rom_ack = 1'b0;
  logic [15:0] rom_dout = 16'h0000;
  logic        busy;

  logic [7:0]  w_data;
  logic        w_req;
  logic [22:0] w_addr;
  logic        w_ack = 1'b0;
  logic [15:0] w_dout = 16'h0000;
  logic        w_busy;

  int checks = 0;
  int errors = 0;

  int   lat = 1;
  logic inject_ack = 1'b0;
  int   cnt = 0;
  logic req_seen = 1'b0;
  int   w_cnt = 0;

  logic [22:0] req_log[$];
  logic [22:0] exp_q[$];

  jt10_adpcma_rom_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .adpcma_addr(adpcma_addr), .adpcma_bank(adpcma_bank), .adpcma_roe_n(adpcma_roe_n),
    .adpcma_data(adpcma_data),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_dout(rom_dout),
    .busy(busy)
  );

  jt10_adpcma_rom_bridge #(.ROM_BASE(BASE_W)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .adpcma_addr(adpcma_addr), .adpcma_bank(adpcma_bank), .adpcma_roe_n(adpcma_roe_n),
    .adpcma_data(w_data),
    .rom_req(w_req), .rom_addr(w_addr), .rom_ack(w_ack), .rom_dout(w_dout),
    .busy(w_busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ROM contents: a fixed pattern, with the word at 0x8 pinned to 16'hA55A.
  function automatic logic [15:0] mem_word(input logic [22:0] wa);
    logic [7:0] lo, hi;
    if (wa == 23'h000008) return 16'hA55A;
    lo = wa[7:0] ^ {1'b0, wa[22:16]} ^ 8'h3C;
    hi = wa[15:8] + wa[7:0] + 8'h17;
    return {hi, lo};
  endfunction

  function automatic logic [23:0] byte_addr(input logic [3:0] bank, input logic [19:0] addr,
                                            input logic [23:0] base);
    return {bank, addr} + base;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [23:0] ba);
    logic [15:0] w;
    w = mem_word(ba[23:1]);
    return ba[0] ? w[15:8] : w[7:0];
  endfunction

  // SDRAM responder for dut: logs each new request, acks after lat clks.
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      rom_ack  = 1'b0;
      cnt      = 0;
      req_seen = 1'b0;
    end else begin
      if (rom_req && !req_seen) req_log.push_back(rom_addr);
      req_seen = rom_req;
      if (rom_ack) begin
        rom_ack = 1'b0;
        cnt     = 0;
      end else if (inject_ack) begin
        rom_ack  = 1'b1;
        rom_dout = 16'hFFFF;
      end else if (rom_req) begin
        cnt++;
        if (cnt >= lat) begin
          rom_ack  = 1'b1;
          rom_dout = mem_word(rom_addr);
        end
      end
    end
  end

  // SDRAM responder for dut_w: fixed two-clk latency.
  always begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      w_ack = 1'b0;
      w_cnt = 0;
    end else if (w_ack) begin
      w_ack = 1'b0;
      w_cnt = 0;
    end else if (w_req) begin
      w_cnt++;
      if (w_cnt >= 2) begin
        w_ack  = 1'b1;
        w_dout = mem_word(w_addr);
      end
    end
  end

  // driver tasks
  task automatic drive_read(input logic [3:0] bank, input logic [19:0] addr);
    @(negedge clk);
    adpcma_bank  = bank;
    adpcma_addr  = addr;
    adpcma_roe_n = 1'b0;
  endtask

  task automatic release_roe();
    @(negedge clk);
    adpcma_roe_n = 1'b1;
  endtask

  // Waits until both bridges have been quiet for two consecutive clks.
  task automatic wait_quiet(output bit timeout);
    int quiet;
    quiet   = 0;
    timeout = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && !rom_req && !w_busy && !w_req) quiet++;
      else quiet = 0;
      if (quiet >= 2) return;
    end
    timeout = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    rst_n        = 1'b0;
    adpcma_roe_n = 1'b1;
    adpcma_addr  = 20'h0;
    adpcma_bank  = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (adpcma_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", adpcma_data); end
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", rom_req); end
    checks++; if (rom_addr !== 23'h0) begin errors++; $display("FAIL reset_addr got %h want 0", rom_addr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_miss();
    lat = 3;
    req_log.delete();
    drive_read(4'h0, 20'h00010);
    @(negedge clk);
    checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL miss_req_t1 got %b want 1", rom_req); end
    checks++; if (rom_addr !== 23'h000008) begin errors++; $display("FAIL miss_addr got %h want 000008", rom_addr); end
    repeat (2) @(negedge clk);
    checks++; if (rom_req !== 1'b1 || adpcma_data !== 8'h00) begin
      errors++; $display("FAIL miss_wait got req=%b data=%h want req=1 data=00", rom_req, adpcma_data); end
    @(negedge clk);
    checks++; if (adpcma_data !== 8'h5A) begin errors++; $display("FAIL miss_data got %h want 5A", adpcma_data); end
    checks++; if (rom_req !== 1'b0) begin errors++; $display("FAIL miss_req_drop got %b want 0", rom_req); end
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL miss_count got %0d want 1", req_log.size()); end
  endtask

  task automatic test_hit();
    adpcma_addr = 20'h00011;
    @(negedge clk);
    checks++; if (adpcma_data !== 8'hA5) begin errors++; $display("FAIL hit_data got %h want A5", adpcma_data); end
    checks++; if (rom_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hit_noreq got req=%b busy=%b want 0 0", rom_req, busy); end
    repeat (3) @(negedge clk);
    checks++; if (req_log.size() != 1) begin errors++; $display("FAIL hit_count got %0d want 1", req_log.size()); end
  endtask

  task automatic test_wrap();
    bit to;
    lat = 2;
    release_roe();
    drive_read(4'hF, 20'hFFFFF);
    @(negedge clk);
    checks++; if (w_req !== 1'b1 || w_addr !== 23'h07FFFF) begin
      errors++; $display("FAIL wrap_addr got req=%b addr=%h want 1 07FFFF", w_req, w_addr); end
    checks++; if (rom_req !== 1'b1 || rom_addr !== 23'h7FFFFF) begin
      errors++; $display("FAIL top_addr got req=%b addr=%h want 1 7FFFFF", rom_req, rom_addr); end
    wait_quiet(to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout got busy want idle"); end
    checks++; if (w_data !== mem_word(23'h07FFFF) >> 8) begin
      errors++; $display("FAIL wrap_data got %h want %h", w_data, mem_word(23'h07FFFF) >> 8); end
    checks++; if (adpcma_data !== exp_byte(byte_addr(4'hF, 20'hFFFFF, 24'h0))) begin
      errors++; $display("FAIL top_data got %h want %h", adpcma_data, exp_byte(24'hFFFFFF)); end
  endtask

  task automatic test_pending();
    bit to;
    lat = 8;
    req_log.delete();
    exp_q = {23'h000100, 23'h000020};
    release_roe();
    drive_read(4'h0, 20'h00200);
    @(negedge clk);
    checks++; if (rom_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pend_req got req=%b busy=%b want 1 1", rom_req, busy); end
    adpcma_addr = 20'h00020;
    @(negedge clk);
    adpcma_addr = 20'h00040;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || rom_addr !== 23'h000100) begin
      errors++; $display("FAIL pend_busy got busy=%b addr=%h want 1 000100", busy, rom_addr); end
    wait_quiet(to);
    checks++; if (to) begin errors++; $display("FAIL pend_timeout got busy want idle"); end
    checks++; if (req_log.size() != exp_q.size()) begin
      errors++; $display("FAIL pend_count got %0d want %0d", req_log.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (req_log[i] !== exp_q[i]) begin
          errors++; $display("FAIL pend_addr[%0d] got %h want %h", i, req_log[i], exp_q[i]); end
      end
    end
    checks++; if (adpcma_data !== exp_byte(24'h000040)) begin
      errors++; $display("FAIL pend_data got %h want %h", adpcma_data, exp_byte(24'h000040)); end
  endtask

  task automatic test_reset_mid();
    bit to;
    lat = 40;
    release_roe();
    drive_read(4'h0, 20'h00300);
    @(negedge clk);
    checks++; if (rom_req !== 1'b1) begin errors++; $display("FAIL rmid_req got %b want 1", rom_req); end
    @(negedge clk);
    rst_n        = 1'b0;
    adpcma_roe_n = 1'b1;
    #1;
    checks++; if (rom_req !== 1'b0 || adpcma_data !== 8'h00 || busy !== 1'b0) begin
      errors++; $display("FAIL rmid_async got req=%b data=%h busy=%b want 0 00 0", rom_req, adpcma_data, busy); end
    repeat (2) @(negedge clk);
    lat   = 2;
    rst_n = 1'b1;
    @(negedge clk);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    @(negedge clk);
    checks++; if (adpcma_data !== 8'h00 || rom_req !== 1'b0) begin
      errors++; $display("FAIL late_ack got data=%h req=%b want 00 0", adpcma_data, rom_req); end
    req_log.delete();
    drive_read(4'h0, 20'h00040);
    @(negedge clk);
    checks++; if (rom_req !== 1'b1 || rom_addr !== 23'h000020) begin
      errors++; $display("FAIL post_reset_miss got req=%b addr=%h want 1 000020", rom_req, rom_addr); end
    wait_quiet(to);
    checks++; if (to || adpcma_data !== exp_byte(24'h000040)) begin
      errors++; $display("FAIL post_reset_data got %h want %h timeout=%b", adpcma_data, exp_byte(24'h000040), to); end
  endtask

  task automatic test_random();
    bit          to;
    logic        m_valid;
    logic [22:0] m_wa;
    logic [3:0]  bank;
    logic [19:0] addr;
    logic [23:0] ba;
    m_valid = 1'b1;
    m_wa    = 23'h000020;
    req_log.delete();
    exp_q.delete();
    for (int n = 0; n < 40; n++) begin
      lat  = $urandom_range(1, 4);
      bank = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      addr = 20'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 0) release_roe();
      drive_read(bank, addr);
      wait_quiet(to);
      ba = byte_addr(bank, addr, 24'h0);
      if (!(m_valid && m_wa == ba[23:1])) exp_q.push_back(ba[23:1]);
      m_valid = 1'b1;
      m_wa    = ba[23:1];
      checks++; if (to || adpcma_data !== exp_byte(ba)) begin
        errors++; $display("FAIL rand_data[%0d] ba=%h got %h want %h timeout=%b", n, ba, adpcma_data, exp_byte(ba), to); end
    end
    checks++; if (req_log.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got %0d want %0d", req_log.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (req_log[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_addr[%0d] got %h want %h", i, req_log[i], exp_q[i]); end
      end
    end
  endtask

`ifdef JT10_ADPCMA_PREFETCH_EN
  task automatic test_prefetch();
    bit to;
    lat = 2;
    req_log.delete();
    exp_q = {23'h000080, 23'h000081};
    drive_read(4'h0, 20'h00100);
    wait_quiet(to);
    checks++; if (to || adpcma_data !== exp_byte(24'h000100)) begin
      errors++; $display("FAIL pf_data0 got %h want %h timeout=%b", adpcma_data, exp_byte(24'h000100), to); end
    adpcma_addr = 20'h00102;
    @(negedge clk);
    checks++; if (adpcma_data !== exp_byte(24'h000102)) begin
      errors++; $display("FAIL pf_data1 got %h want %h", adpcma_data, exp_byte(24'h000102)); end
    exp_q.push_back(23'h000082);
    wait_quiet(to);
    checks++; if (to || req_log.size() != exp_q.size()) begin
      errors++; $display("FAIL pf_count got %0d want %0d timeout=%b", req_log.size(), exp_q.size(), to); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++; if (req_log[i] !== exp_q[i]) begin
          errors++; $display("FAIL pf_addr[%0d] got %h want %h", i, req_log[i], exp_q[i]); end
      end
    end
  endtask
`endif

  // sequence and final report
  initial begin
    test_reset();
`ifdef JT10_ADPCMA_PREFETCH_EN
    test_prefetch();
`else
    test_miss();
    test_hit();
    test_wrap();
    test_pending();
    test_reset_mid();
    test_random();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
